hc595_driver: RTL and testbench
===============================

HC595_DRIVER -- requirements
Module: hc595_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of bits shifted per transfer (≥1).
REQ-002 SHALL have parameter CLK_DIV, default 4: SRCLK half-period in CLK cycles (≥1; 0 illegal).
REQ-003 SHALL have CLK  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have Rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have Start  input  1  transfer request, sampled at rising CLK edge.
REQ-006 SHALL have Data  input  WIDTH  parallel word to send, captured with Start.
REQ-007 SHALL have Busy  output  1  high from accepted Start through the Done cycle.
REQ-008 SHALL have Done  output  1  one-cycle pulse: word latched into external register.
REQ-009 SHALL have SER  output  1  serial data to external shift register.
REQ-010 SHALL have SRCLK  output  1  shift clock; external shift on its rising edge.
REQ-011 SHALL have RCLK  output  1  storage-latch clock; external latch on its rising edge.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE; all outputs registered.
REQ-013 IDLE: Start=1 SHALL capture Data into shift register, load bit counter with WIDTH, drive SER with first bit, set Busy=1, go SHIFT_LO.
REQ-014 SHIFT_LO SHALL hold SRCLK=0 for exactly CLK_DIV cycles with SER stable, then go SHIFT_HI.
REQ-015 SHIFT_HI SHALL hold SRCLK=1 for exactly CLK_DIV cycles, SER unchanged; at its end, decrement bit counter; if nonzero, present next bit on SER and go SHIFT_LO, else go LATCH.
REQ-016 LATCH SHALL drive SRCLK=0, RCLK=1 for exactly CLK_DIV cycles, then RCLK=0 and go DONE.
REQ-017 DONE SHALL assert Done=1 for one cycle, keep Busy=1, then go IDLE with Busy=0.
REQ-018 Latency from Start-sampling edge to Done assertion SHALL be 2*WIDTH*CLK_DIV + CLK_DIV cycles (68 at defaults).
REQ-019 Start while Busy=1 SHALL be ignored, not queued; Data changes after capture SHALL not affect the transfer.
REQ-020 Start held high continuously SHALL start a new transfer on the first IDLE cycle after each Done.
REQ-021 SER SHALL change only while SRCLK=0 (at least CLK_DIV cycles of setup before the rising edge).
REQ-022 RCLK SHALL never be high while SRCLK is high; exactly one RCLK pulse per transfer.
REQ-023 Default bit order SHALL be MSB first, so the external parallel output bit i equals Data[i] after latch.

Reset
REQ-024 Rst=0 SHALL immediately force IDLE, Busy=0, Done=0, SER=0, SRCLK=0, RCLK=0, counters and shift register cleared.
REQ-025 Reset mid-transfer SHALL abort without any RCLK pulse, leaving the external latched value unchanged.
REQ-026 First Start SHALL be accepted on the first rising edge after Rst deasserts.

Configuration
REQ-027 Macro HC595_LSBFIRST_EN defined SHALL shift Data[0] first (LSB first); undefined SHALL shift Data[WIDTH-1] first; timing identical either way.

Verification
REQ-028 Defaults, Data=8'hA5, Start pulse -> SER sequence at SRCLK rises 1,0,1,0,0,1,0,1; one RCLK pulse 4 cycles wide; Done at cycle 68.
REQ-029 Start again at cycle 10 of a transfer with Data=8'hFF -> ignored; first word completes unchanged; no second RCLK.
REQ-030 Rst low at cycle 30 of transfer -> all outputs 0 asynchronously; zero RCLK pulses; next Start sends full word normally.
REQ-031 Start held high, Data=8'h01 then 8'h80 -> back-to-back transfers, Done pulses 70 cycles apart (68 + DONE + IDLE), each word correct.
REQ-032 CLK_DIV=1, WIDTH=4, Data=4'b0011 -> SRCLK toggles every cycle; Done at cycle 9; SER checked at each SRCLK rise.
REQ-033 HC595_LSBFIRST_EN defined, Data=8'h01 -> first SER bit 1, remaining 0; Done still at cycle 68.

Source files
------------

// File: rtl/hc595_driver.sv
// hc595_driver: serial loader for a 74HC595-style shift/storage register pair.
// Optional macro HC595_LSBFIRST_EN: shift Data[0] first instead of Data[WIDTH-1].
`default_nettype none

module hc595_driver #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             ser_o,
  output logic             srclk_o,
  output logic             rclk_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    LATCH    = 3'd3,
    DONE     = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, sreg_next;
  logic             busy_q, done_q, srclk_q, rclk_q;
  logic             busy_d, done_d, srclk_d, rclk_d;
  logic             div_last;

  // SER is taken straight from the shift register so it is a flop output.
`ifdef HC595_LSBFIRST_EN
  assign sreg_next = sreg_q >> 1;
  assign ser_o     = sreg_q[0];
`else
  assign sreg_next = sreg_q << 1;
  assign ser_o     = sreg_q[WIDTH-1];
`endif

  assign div_last = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          sreg_d  = data_i;
          cnt_d   = CNT_LOAD;
          div_d   = '0;
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_last) begin
          div_d   = '0;
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      SHIFT_HI: begin
        if (div_last) begin
          div_d = '0;
          cnt_d = cnt_q - CNT_ONE;
          // Next bit appears together with the falling SRCLK edge.
          if (cnt_q != CNT_ONE) begin
            sreg_d  = sreg_next;
            state_d = SHIFT_LO;
          end else begin
            state_d = LATCH;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      LATCH: begin
        if (div_last) begin
          div_d   = '0;
          state_d = DONE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin levels are decoded from the next state and registered, so they are glitch-free.
  assign busy_d  = (state_d != IDLE);
  assign done_d  = (state_d == DONE);
  assign srclk_d = (state_d == SHIFT_HI);
  assign rclk_d  = (state_d == LATCH);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      sreg_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      srclk_q <= 1'b0;
      rclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      srclk_q <= srclk_d;
      rclk_q  <= rclk_d;
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign srclk_o = srclk_q;
  assign rclk_o  = rclk_q;

endmodule

`default_nettype wire

// File: tb/tb_hc595_driver.sv
// tb_hc595_driver: scoreboard bench with a behavioural 74HC595 model on the outputs.
`default_nettype none

module tb_hc595_driver;

  localparam int W    = 8;
  localparam int D    = 4;
  localparam int LAT  = 2 * W * D + D;
  localparam int WB   = 4;
  localparam int DB   = 1;
  localparam int LATB = 2 * WB * DB + DB;
`ifdef HC595_LSBFIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_a = 1'b0, start_b = 1'b0;
  logic [W-1:0]  data_a = '0;
  logic [WB-1:0] data_b = '0;
  logic          busy_a, done_a, ser_a, srclk_a, rclk_a;
  logic          busy_b, done_b, ser_b, srclk_b, rclk_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rclk_cnt = 0;

  bit           ser_q[$];
  logic [W-1:0] word_q[$];
  int           done_q[$];

  logic [W-1:0] ext_sr = '0;
  logic [W-1:0] ext_lat = '0;

  hc595_driver #(.WIDTH(W), .CLK_DIV(D)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .data_i(data_a),
    .busy_o(busy_a), .done_o(done_a), .ser_o(ser_a), .srclk_o(srclk_a), .rclk_o(rclk_a)
  );

  hc595_driver #(.WIDTH(WB), .CLK_DIV(DB)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .data_i(data_b),
    .busy_o(busy_b), .done_o(done_b), .ser_o(ser_b), .srclk_o(srclk_b), .rclk_o(rclk_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External 74HC595: shift on SRCLK rise, latch on RCLK rise, no reset.
  always @(posedge srclk_a) ext_sr <= {ext_sr[W-2:0], ser_a};
  always @(posedge rclk_a) ext_lat <= ext_sr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit ser_bit(input logic [W-1:0] d, input int i);
    return LSB ? d[i] : d[W-1-i];
  endfunction

  function automatic logic [W-1:0] ext_word(input logic [W-1:0] d);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[W-1-i] = ser_bit(d, i);
    return r;
  endfunction

  task automatic push_exp(input logic [W-1:0] d, input int done_cyc);
    for (int i = 0; i < W; i++) ser_q.push_back(ser_bit(d, i));
    word_q.push_back(ext_word(d));
    done_q.push_back(done_cyc);
  endtask

  // Called at a negedge; the next posedge samples Start.
  task automatic launch(input logic [W-1:0] d);
    start_a = 1'b1;
    data_a  = d;
    push_exp(d, cyc + 1 + LAT);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done_a && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done_a) check("done_timeout", 0, 1);
  endtask

  logic srclk_p = 1'b0, rclk_p = 1'b0;
  int   rclk_rise = 0;

  always @(negedge clk) begin
    if (srclk_a && !srclk_p) begin
      if (ser_q.size() == 0) check("unexpected_shift", 1, 0);
      else check("ser_bit", ser_a, ser_q.pop_front());
      check("rclk_low_during_srclk", rclk_a, 0);
    end
    if (rclk_a && !rclk_p) begin
      rclk_cnt++;
      rclk_rise = cyc;
      if (word_q.size() == 0) check("unexpected_latch", 1, 0);
      else check("latched_word", ext_lat, word_q.pop_front());
    end
    if (!rclk_a && rclk_p && rst_n) check("rclk_width", cyc - rclk_rise, D);
    if (done_a) begin
      if (done_q.size() == 0) check("unexpected_done", 1, 0);
      else check("done_cycle", cyc, done_q.pop_front());
    end
    srclk_p = srclk_a;
    rclk_p  = rclk_a;
  end

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] exp_par;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n0, t1, nb, t;
    logic [W-1:0] lat0;
    logic [WB-1:0] bits_got;
    int nbits;
    bit gotdone;

    vecs[0] = '{8'hA5, 8'hA5};
    vecs[1] = '{8'h3C, 8'h3C};
    vecs[2] = '{8'h00, 8'h00};
    vecs[3] = '{8'hFF, 8'hFF};
    vecs[4] = '{8'h01, 8'h01};
    vecs[5] = '{8'h80, 8'h80};

    repeat (3) @(negedge clk);
    check("reset_outputs_a", {busy_a, done_a, ser_a, srclk_a, rclk_a}, 5'b0);
    check("reset_outputs_b", {busy_b, done_b, ser_b, srclk_b, rclk_b}, 5'b0);

    // Release reset and request in the same cycle: first edge must accept.
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n0 = rclk_cnt;
      launch(vecs[i].data);
      @(negedge clk);
      start_a = 1'b0;
      check("busy_after_start", busy_a, 1);
      check("ser_first_bit", ser_a, ser_bit(vecs[i].data, 0));
      wait_done(LAT + 10);
      @(negedge clk);
      check("busy_after_done", {busy_a, done_a}, 2'b00);
      check("parallel_out", ext_lat, LSB ? ext_word(vecs[i].exp_par) : vecs[i].exp_par);
      check("rclk_pulses", rclk_cnt - n0, 1);
    end

    // Start during a transfer is ignored and Data changes do not leak in.
    n0 = rclk_cnt;
    launch(8'h5A);
    @(negedge clk);
    start_a = 1'b0;
    repeat (9) @(negedge clk);
    start_a = 1'b1;
    data_a  = 8'hFF;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(LAT + 10);
    repeat (5) begin
      @(negedge clk);
      check("ignored_start_idle", busy_a, 0);
    end
    check("ignored_start_word", ext_lat, ext_word(8'h5A));
    check("ignored_start_rclk", rclk_cnt - n0, 1);

    // Asynchronous abort mid-transfer.
    lat0 = ext_lat;
    n0   = rclk_cnt;
    launch(8'hC3);
    @(negedge clk);
    start_a = 1'b0;
    repeat (29) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {busy_a, done_a, ser_a, srclk_a, rclk_a}, 5'b0);
    ser_q.delete();
    word_q.delete();
    done_q.delete();
    repeat (3) @(negedge clk);
    check("abort_latch_kept", ext_lat, lat0);
    check("abort_no_rclk", rclk_cnt - n0, 0);
    rst_n = 1'b1;
    launch(8'h96);
    @(negedge clk);
    start_a = 1'b0;
    wait_done(LAT + 10);
    @(negedge clk);
    check("after_abort_word", ext_lat, ext_word(8'h96));

    // Start held high: back-to-back transfers 70 cycles apart.
    @(negedge clk);
    n0 = rclk_cnt;
    launch(8'h01);
    push_exp(8'h80, cyc + 1 + LAT + 2 + LAT);
    @(negedge clk);
    data_a = 8'h80;
    wait_done(LAT + 10);
    t1 = cyc;
    check("b2b_first_word", ext_lat, ext_word(8'h01));
    @(negedge clk);
    @(negedge clk);
    check("b2b_restart_busy", busy_a, 1);
    start_a = 1'b0;
    wait_done(LAT + 10);
    check("b2b_done_spacing", cyc - t1, LAT + 2);
    check("b2b_second_word", ext_lat, ext_word(8'h80));
    check("b2b_rclk", rclk_cnt - n0, 2);

    // Minimum divider, 4-bit word on the second instance.
    @(negedge clk);
    nb = cyc;
    start_b = 1'b1;
    data_b  = 4'b0011;
    nbits = 0;
    bits_got = '0;
    gotdone = 1'b0;
    for (t = 1; t <= LATB + 5 && !gotdone; t++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (t <= 2 * WB * DB) begin
        check("b_srclk_toggle", srclk_b, (t % 2) == 0);
        if (srclk_b && nbits < WB) begin
          check("b_ser_bit", ser_b, LSB ? data_b[nbits] : data_b[WB-1-nbits]);
          nbits++;
        end
      end
      if (t == 2 * WB * DB + 1) check("b_rclk", {srclk_b, rclk_b}, 2'b01);
      if (done_b) begin
        gotdone = 1'b1;
        check("b_done_cycle", cyc - nb, LATB + 1);
      end
    end
    if (!gotdone) check("b_done_timeout", 0, 1);
    check("b_bit_count", nbits, WB);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", ser_q.size() + word_q.size() + done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
